// File: rtl/sva_collect_pkg.sv
// Shared types for the SVA result collector: record layout, FSM states, saturating increment.
package sva_collect_pkg;

  localparam int REC_PERIOD_W = 16;
  localparam int REC_CNT_W    = 8;

  typedef enum logic {
    IDLE    = 1'b0,
    COLLECT = 1'b1
  } coll_state_e;

  // Record layout at the default widths, MSB first.
  typedef struct packed {
    logic [REC_PERIOD_W-1:0] period;
    logic [REC_CNT_W-1:0]    succ_cnt;
    logic [REC_CNT_W-1:0]    fail_cnt;
    logic [REC_CNT_W-1:0]    lazy_cnt;
  } rec_t;

  function automatic logic [63:0] sat_inc(input logic [63:0] val, input logic [63:0] max_val,
                                          input logic inc);
    return (inc && (val < max_val)) ? val + 64'd1 : val;
  endfunction

endpackage

// File: rtl/sva_result_collector_if.sv
// Record stream handshake between the collector (master) and its consumer (slave).
interface sva_result_collector_if #(
  parameter int DW = 40
);
  logic          rec_valid;
  logic          rec_ready;
  logic [DW-1:0] rec_data;

  modport master (output rec_valid, output rec_data, input rec_ready);
  modport slave  (input rec_valid, input rec_data, output rec_ready);
endinterface

// File: rtl/sva_rec_fifo.sv
// First-word-fall-through record FIFO; head visible the cycle after a push into an empty FIFO.
// A push while full succeeds only when a pop happens in the same cycle; a pop while empty is ignored.
module sva_rec_fifo #(
  parameter int WIDTH = 40,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_dat_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_dat_o,
  output logic             full_o,
  output logic             empty_o
);
  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr_q, rd_ptr_q;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             pop_ok, push_ok;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign empty_o    = (wr_ptr_q == rd_ptr_q);
  assign full_o     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign pop_ok     = pop_i & ~empty_o;
  assign push_ok    = push_i & (~full_o | pop_ok);
  assign head_dat_o = mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= push_dat_i;
  end

endmodule

// File: rtl/sva_result_collector.sv
// Counts SVA verdicts per gclk window and queues {period, succ, fail, lazy} records (1-cycle latency, full+no-pop drops).
// Optional SVA_COLLECT_SKIP_EMPTY_EN: all-zero windows are closed without a push.
module sva_result_collector
  import sva_collect_pkg::*;
#(
  parameter int CNT_WIDTH    = 8,
  parameter int PERIOD_WIDTH = 16,
  parameter int FIFO_DEPTH   = 4,
  parameter int TOTAL_WIDTH  = 32
) (
  input  logic                   sys_clk,
  input  logic                   sys_rst,
  input  logic                   gclk,
  input  logic                   grst,
  input  logic                   succ,
  input  logic                   fail,
  input  logic                   lazy_succ,
  sva_result_collector_if.master rec,
  output logic [TOTAL_WIDTH-1:0] total_succ,
  output logic [TOTAL_WIDTH-1:0] total_fail,
  output logic [TOTAL_WIDTH-1:0] total_lazy,
  output logic                   overflow,
  output logic [7:0]             drop_cnt,
  output logic                   busy
);
  localparam int          REC_W    = PERIOD_WIDTH + 3 * CNT_WIDTH;
  localparam logic [63:0] CNT_MAX  = 64'({CNT_WIDTH{1'b1}});
  localparam logic [63:0] TOT_MAX  = 64'({TOTAL_WIDTH{1'b1}});
  localparam logic [63:0] DROP_MAX = 64'd255;

  coll_state_e             state_q;
  logic                    sync_d0_q, sync_d1_q, gclk_pf;
  logic [PERIOD_WIDTH-1:0] period_q;
  logic [CNT_WIDTH-1:0]    succ_cnt_q, fail_cnt_q, lazy_cnt_q;
  logic [CNT_WIDTH-1:0]    succ_cnt_d, fail_cnt_d, lazy_cnt_d;
  logic [TOTAL_WIDTH-1:0]  tot_succ_q, tot_fail_q, tot_lazy_q;
  logic [TOTAL_WIDTH-1:0]  tot_succ_d, tot_fail_d, tot_lazy_d;
  logic                    overflow_q, overflow_d;
  logic [7:0]              drop_cnt_q, drop_cnt_d;
  logic                    win_close, win_push, rec_pop, fifo_full, fifo_empty;
  logic [REC_W-1:0]        rec_d, head_dat;

  assign gclk_pf   = sync_d0_q & ~sync_d1_q;
  assign win_close = (state_q == COLLECT) & gclk_pf & ~grst;
`ifdef SVA_COLLECT_SKIP_EMPTY_EN
  assign win_push  = win_close & ((succ_cnt_q | fail_cnt_q | lazy_cnt_q) != '0);
`else
  assign win_push  = win_close;
`endif
  assign rec_pop   = rec.rec_valid & rec.rec_ready;
  assign rec_d     = {period_q, succ_cnt_q, fail_cnt_q, lazy_cnt_q};

  always_comb begin
    succ_cnt_d = CNT_WIDTH'(sat_inc(64'(succ_cnt_q), CNT_MAX, succ));
    fail_cnt_d = CNT_WIDTH'(sat_inc(64'(fail_cnt_q), CNT_MAX, fail));
    lazy_cnt_d = CNT_WIDTH'(sat_inc(64'(lazy_cnt_q), CNT_MAX, lazy_succ));
    tot_succ_d = TOTAL_WIDTH'(sat_inc(64'(tot_succ_q), TOT_MAX, succ));
    tot_fail_d = TOTAL_WIDTH'(sat_inc(64'(tot_fail_q), TOT_MAX, fail));
    tot_lazy_d = TOTAL_WIDTH'(sat_inc(64'(tot_lazy_q), TOT_MAX, lazy_succ));
    overflow_d = overflow_q;
    drop_cnt_d = drop_cnt_q;
    if (win_push & fifo_full & ~rec_pop) begin
      overflow_d = 1'b1;
      drop_cnt_d = 8'(sat_inc(64'(drop_cnt_q), DROP_MAX, 1'b1));
    end
  end

  // Window FSM; grst discards the open window without pushing it.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q    <= IDLE;
      sync_d0_q  <= 1'b0;
      sync_d1_q  <= 1'b0;
      period_q   <= '0;
      succ_cnt_q <= '0;
      fail_cnt_q <= '0;
      lazy_cnt_q <= '0;
    end else if (grst) begin
      state_q    <= IDLE;
      sync_d0_q  <= 1'b0;
      sync_d1_q  <= 1'b0;
      period_q   <= '0;
      succ_cnt_q <= '0;
      fail_cnt_q <= '0;
      lazy_cnt_q <= '0;
    end else begin
      sync_d0_q <= gclk;
      sync_d1_q <= sync_d0_q;
      case (state_q)
        IDLE: begin
          if (gclk_pf) begin
            state_q    <= COLLECT;
            period_q   <= '0;
            succ_cnt_q <= '0;
            fail_cnt_q <= '0;
            lazy_cnt_q <= '0;
          end
        end
        COLLECT: begin
          if (gclk_pf) begin
            period_q   <= period_q + PERIOD_WIDTH'(1);
            succ_cnt_q <= CNT_WIDTH'(succ);
            fail_cnt_q <= CNT_WIDTH'(fail);
            lazy_cnt_q <= CNT_WIDTH'(lazy_succ);
          end else begin
            succ_cnt_q <= succ_cnt_d;
            fail_cnt_q <= fail_cnt_d;
            lazy_cnt_q <= lazy_cnt_d;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      tot_succ_q <= '0;
      tot_fail_q <= '0;
      tot_lazy_q <= '0;
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      tot_succ_q <= tot_succ_d;
      tot_fail_q <= tot_fail_d;
      tot_lazy_q <= tot_lazy_d;
      overflow_q <= overflow_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  sva_rec_fifo #(
    .WIDTH (REC_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk        (sys_clk),
    .rst        (sys_rst),
    .push_i     (win_push),
    .push_dat_i (rec_d),
    .pop_i      (rec_pop),
    .head_dat_o (head_dat),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty)
  );

  assign rec.rec_valid = ~fifo_empty;
  assign rec.rec_data  = head_dat;
  assign total_succ    = tot_succ_q;
  assign total_fail    = tot_fail_q;
  assign total_lazy    = tot_lazy_q;
  assign overflow      = overflow_q;
  assign drop_cnt      = drop_cnt_q;
  assign busy          = (state_q == COLLECT) | rec.rec_valid;

endmodule

// File: tb/tb_sva_result_collector.sv
// Self-checking bench for sva_result_collector: queue-based reference model, vector table, directed corner sequences.
`timescale 1ns/1ps
module tb_sva_result_collector;
  import sva_collect_pkg::*;

  localparam int  CW = 8, PW = 16, DEPTH = 4, TW = 32, RW = PW + 3 * CW;
  localparam longint TOT_MAX = 64'hFFFF_FFFF;

  logic          sys_clk = 1'b0;
  logic          sys_rst, gclk, grst, succ, fail, lazy_succ;
  logic [TW-1:0] total_succ, total_fail, total_lazy;
  logic          overflow, busy;
  logic [7:0]    drop_cnt;

  sva_result_collector_if #(.DW(RW)) rec ();

  sva_result_collector #(
    .CNT_WIDTH(CW), .PERIOD_WIDTH(PW), .FIFO_DEPTH(DEPTH), .TOTAL_WIDTH(TW)
  ) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .gclk(gclk), .grst(grst),
    .succ(succ), .fail(fail), .lazy_succ(lazy_succ), .rec(rec),
    .total_succ(total_succ), .total_fail(total_fail), .total_lazy(total_lazy),
    .overflow(overflow), .drop_cnt(drop_cnt), .busy(busy)
  );

  always #5 sys_clk = ~sys_clk;

  int n_assert = 0, n_fail = 0;

  // Reference model state
  bit     m_collect = 0;
  int     m_period = 0, m_s = 0, m_f = 0, m_l = 0, m_drop = 0;
  bit     m_ovf = 0, gseen1 = 0, gseen2 = 0;
  longint m_ts = 0, m_tf = 0, m_tl = 0;
  rec_t   m_q[$];
  rec_t   got_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int sat(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  // One sys_clk cycle: drive, advance, update model, compare every output.
  task automatic step(input bit g, input bit gr, input bit s, input bit f, input bit l, input bit rdy);
    bit   pf, pop;
    rec_t r;
    gclk = g; grst = gr; succ = s; fail = f; lazy_succ = l; rec.rec_ready = rdy;
    pf  = gseen1 & ~gseen2;
    pop = (m_q.size() > 0) && rdy;
    if (pop) got_q.push_back(rec_t'(rec.rec_data));
    @(posedge sys_clk); #1;
    m_ts = (m_ts + s > TOT_MAX) ? TOT_MAX : m_ts + s;
    m_tf = (m_tf + f > TOT_MAX) ? TOT_MAX : m_tf + f;
    m_tl = (m_tl + l > TOT_MAX) ? TOT_MAX : m_tl + l;
    if (pop) void'(m_q.pop_front());
    if (gr) begin
      m_collect = 0; m_period = 0; m_s = 0; m_f = 0; m_l = 0;
    end else if (m_collect && pf) begin
      r.period = m_period[PW-1:0]; r.succ_cnt = m_s[CW-1:0];
      r.fail_cnt = m_f[CW-1:0]; r.lazy_cnt = m_l[CW-1:0];
`ifdef SVA_COLLECT_SKIP_EMPTY_EN
      if (m_s + m_f + m_l > 0) begin
`else
      begin
`endif
        if (m_q.size() < DEPTH) m_q.push_back(r);
        else begin
          m_ovf = 1; m_drop = sat(m_drop + 1, 255);
        end
      end
      m_period = (m_period + 1) % (1 << PW);
      m_s = s; m_f = f; m_l = l;
    end else if (m_collect) begin
      m_s = sat(m_s + s, 255); m_f = sat(m_f + f, 255); m_l = sat(m_l + l, 255);
    end else if (pf) begin
      m_collect = 1; m_period = 0; m_s = 0; m_f = 0; m_l = 0;
    end
    gseen2 = gr ? 1'b0 : gseen1;
    gseen1 = gr ? 1'b0 : g;
    chk("rec_valid", 64'(rec.rec_valid), 64'(m_q.size() > 0));
    if (m_q.size() > 0) chk("rec_data", 64'(rec.rec_data), 64'(m_q[0]));
    chk("total_succ", 64'(total_succ), 64'(m_ts));
    chk("total_fail", 64'(total_fail), 64'(m_tf));
    chk("total_lazy", 64'(total_lazy), 64'(m_tl));
    chk("overflow", 64'(overflow), 64'(m_ovf));
    chk("drop_cnt", 64'(drop_cnt), 64'(m_drop));
    chk("busy", 64'(busy), 64'(m_collect | (m_q.size() > 0)));
  endtask

  // One gclk period: verdict bursts early, gclk high for the last two cycles, so the
  // window boundary lands on the final cycle (where an optional coincident fail is placed).
  task automatic gperiod(input int ns, input int nf, input int nl, input bit at_edge_f, input bit rdy);
    int len, m;
    m = ns;
    if (nf > m) m = nf;
    if (nl > m) m = nl;
    len = m + 4;
    for (int i = 0; i < len; i++)
      step(i >= len - 2, 1'b0, i < ns, (i < nf) || (at_edge_f && i == len - 1), i < nl, rdy);
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, rdy);
  endtask

  task automatic last_rec(output rec_t r);
    r = '0;
    chk("rec_delivered", 64'(got_q.size() > 0), 64'd1);
    if (got_q.size() > 0) r = got_q[got_q.size() - 1];
  endtask

  typedef struct {
    int ns, nf, nl;
    logic [PW-1:0] ep;
    logic [CW-1:0] es, ef, el;
  } vec_t;

  vec_t   tbl[4];
  rec_t   r;
  longint ts0;

  initial begin
    tbl[0] = '{ns: 2,   nf: 1,   nl: 0, ep: 1, es: 2,   ef: 1,   el: 0};
    tbl[1] = '{ns: 0,   nf: 0,   nl: 3, ep: 2, es: 0,   ef: 0,   el: 3};
    tbl[2] = '{ns: 300, nf: 0,   nl: 0, ep: 3, es: 255, ef: 0,   el: 0};
    tbl[3] = '{ns: 4,   nf: 260, nl: 1, ep: 4, es: 4,   ef: 255, el: 1};

    sys_rst = 1; gclk = 0; grst = 0; succ = 0; fail = 0; lazy_succ = 0; rec.rec_ready = 0;
    repeat (2) @(posedge sys_clk);
    #1;
    chk("rst_rec_valid", 64'(rec.rec_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_total_succ", 64'(total_succ), 64'd0);
    chk("rst_overflow", 64'(overflow), 64'd0);
    chk("rst_drop_cnt", 64'(drop_cnt), 64'd0);
    sys_rst = 0;

    // Open the first window, close an empty period 0, then the vector table.
    gperiod(0, 0, 0, 0, 1);
    gperiod(0, 0, 0, 0, 1);
    for (int i = 0; i < 4; i++) begin
      ts0 = longint'(total_succ);
      gperiod(tbl[i].ns, tbl[i].nf, tbl[i].nl, 0, 1);
      idle(2, 1);
      last_rec(r);
      chk($sformatf("tbl%0d_period", i), 64'(r.period), 64'(tbl[i].ep));
      chk($sformatf("tbl%0d_succ", i), 64'(r.succ_cnt), 64'(tbl[i].es));
      chk($sformatf("tbl%0d_fail", i), 64'(r.fail_cnt), 64'(tbl[i].ef));
      chk($sformatf("tbl%0d_lazy", i), 64'(r.lazy_cnt), 64'(tbl[i].el));
      chk($sformatf("tbl%0d_total_succ_delta", i), 64'(longint'(total_succ) - ts0), 64'(tbl[i].ns));
      if (i == 0) chk("total_succ_first", 64'(total_succ), 64'd2);
    end

    // Fail coincident with the window boundary goes to the next window.
    gperiod(1, 0, 0, 1, 1);
    gperiod(0, 0, 0, 0, 1);
    idle(2, 1);
    chk("edge_fail_recs", 64'(got_q.size() >= 2), 64'd1);
    if (got_q.size() >= 2) begin
      chk("edge_close_period", 64'(got_q[got_q.size()-2].period), 64'd5);
      chk("edge_close_fail", 64'(got_q[got_q.size()-2].fail_cnt), 64'd0);
      chk("edge_next_fail", 64'(got_q[got_q.size()-1].fail_cnt), 64'd1);
    end

    // Backpressure: six windows into a 4-deep FIFO.
    step(0, 1, 0, 0, 0, 1);
    got_q.delete();
    gperiod(0, 0, 0, 0, 0);
    for (int i = 0; i < 6; i++) gperiod(0, 0, 1, 0, 0);
    chk("ovf_overflow", 64'(overflow), 64'd1);
    chk("ovf_drop_cnt", 64'(drop_cnt), 64'd2);
    idle(6, 1);
    chk("ovf_held", 64'(got_q.size()), 64'd4);
    for (int i = 0; i < 4; i++)
      if (i < got_q.size()) chk($sformatf("ovf_period%0d", i), 64'(got_q[i].period), 64'(i));

    // grst mid-window with one record queued.
    got_q.delete();
    gperiod(0, 0, 1, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 1, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0);
    idle(3, 1);
    chk("grst_queued_count", 64'(got_q.size()), 64'd1);
    last_rec(r);
    chk("grst_queued_period", 64'(r.period), 64'd6);
    gperiod(0, 0, 0, 0, 1);
    gperiod(0, 1, 0, 0, 1);
    idle(2, 1);
    last_rec(r);
    chk("grst_restart_period", 64'(r.period), 64'd0);
    chk("grst_restart_succ", 64'(r.succ_cnt), 64'd0);
    chk("grst_restart_fail", 64'(r.fail_cnt), 64'd1);

    // Three empty windows followed by one succ window.
    step(0, 1, 0, 0, 0, 1);
    got_q.delete();
    gperiod(0, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) gperiod(0, 0, 0, 0, 1);
    gperiod(1, 0, 0, 0, 1);
    idle(2, 1);
`ifdef SVA_COLLECT_SKIP_EMPTY_EN
    chk("skip_count", 64'(got_q.size()), 64'd1);
`else
    chk("skip_count", 64'(got_q.size()), 64'd4);
`endif
    last_rec(r);
    chk("skip_period", 64'(r.period), 64'd3);
    chk("skip_succ", 64'(r.succ_cnt), 64'd1);

    // Randomised traffic against the model.
    begin
      bit g = 0;
      for (int i = 0; i < 3000; i++) begin
        if ($urandom_range(0, 5) == 0) g = ~g;
        step(g, $urandom_range(0, 199) == 0, $urandom_range(0, 2) == 0,
             $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0, $urandom_range(0, 1) == 1);
      end
    end

    // Asynchronous system reset away from any clock edge.
    #2 sys_rst = 1;
    #1;
    chk("arst_rec_valid", 64'(rec.rec_valid), 64'd0);
    chk("arst_busy", 64'(busy), 64'd0);
    chk("arst_total_fail", 64'(total_fail), 64'd0);
    chk("arst_overflow", 64'(overflow), 64'd0);
    chk("arst_drop_cnt", 64'(drop_cnt), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/sva_result_collector.md
SVA_RESULT_COLLECTOR -- requirements
Module: sva_result_collector

Interface
REQ-001 Parameter CNT_WIDTH, default 8, width of per-window event counters.
REQ-002 Parameter PERIOD_WIDTH, default 16, width of the gclk period index.
REQ-003 Parameter FIFO_DEPTH, default 4, record FIFO depth, power of two, 2..64.
REQ-004 Parameter TOTAL_WIDTH, default 32, width of the cumulative totals.
REQ-005 sys_clk  in  1  sole clock; all logic on its rising edge.
REQ-006 sys_rst  in  1  asynchronous, active-high reset.
REQ-007 gclk  in  1  user clock, sampled as data; grst  in  1  user reset, level, sampled synchronously.
REQ-008 succ / fail / lazy_succ  in  1 each  single-cycle verdict pulses from the checker stage; any combination may be high in the same cycle.
REQ-009 rec_valid  out  1; rec_ready  in  1; rec_data  out  PERIOD_WIDTH+3*CNT_WIDTH  {period, succ_cnt, fail_cnt, lazy_cnt}, MSB first.
REQ-010 total_succ / total_fail / total_lazy  out  TOTAL_WIDTH each; overflow  out  1; drop_cnt  out  8; busy  out  1.

Function
REQ-011 gclk passes through a two-flop synchroniser; gclk_pf = d0 & ~d1; both flops clear while grst is high.
REQ-012 FSM states: IDLE, COLLECT; IDLE -> COLLECT on the first gclk_pf; COLLECT -> COLLECT on every gclk_pf; any state -> IDLE while grst is high.
REQ-013 In IDLE, verdict pulses are ignored by the window counters but still update the totals.
REQ-014 In COLLECT, each high verdict input increments its window counter by 1, saturating at 2^CNT_WIDTH-1.
REQ-015 On gclk_pf in COLLECT, the current {period, counters} forms a record pushed to the FIFO that cycle; the counters then restart from the verdicts present in that same cycle (0 or 1), so a verdict coincident with gclk_pf belongs to the new window.
REQ-016 The period index starts at 0 on IDLE->COLLECT, increments by 1 per closed window, and wraps modulo 2^PERIOD_WIDTH.
REQ-017 The FIFO is first-word-fall-through: rec_valid = not empty; rec_data is the head; a pop occurs when rec_valid & rec_ready.
REQ-018 If a push occurs while full and no pop occurs that cycle, the record is dropped, overflow is set (sticky), and drop_cnt increments, saturating at 255.
REQ-019 If a push occurs while full and a pop occurs in the same cycle, the push succeeds.
REQ-020 A pop while empty has no effect.
REQ-021 The totals count every verdict pulse in any state and saturate at 2^TOTAL_WIDTH-1.
REQ-022 busy = (state == COLLECT) | rec_valid.
REQ-023 Latency: a record is visible on rec_data one cycle after the gclk_pf cycle when the FIFO was empty.

Reset
REQ-024 sys_rst clears: state IDLE, sync flops, counters, period, FIFO pointers, rec_valid 0, totals 0, overflow 0, drop_cnt 0, busy 0.
REQ-025 grst clears only the sync flops, state, window counters and period; FIFO contents, totals, overflow and drop_cnt are kept.
REQ-026 grst asserted mid-window discards the open window with no push.

Configuration
REQ-027 With SVA_COLLECT_SKIP_EMPTY_EN defined, a closing window whose three counters are all 0 is not pushed and does not count as a drop; the period still increments.
REQ-028 Without SVA_COLLECT_SKIP_EMPTY_EN, every closed window is pushed.

Structure
REQ-029 Package sva_collect_pkg holds the record struct typedef, the IDLE/COLLECT enum, and the saturating-increment function.
REQ-030 The FIFO is a sub-module sva_rec_fifo (parameterised width/depth, full/empty, FWFT), instantiated once.

Verification
REQ-031 Three gclk periods with 2 succ, 1 fail, 0 lazy in period 1 and rec_ready=1 -> record {period=1, succ_cnt=2, fail_cnt=1, lazy_cnt=0}; total_succ=2.
REQ-032 A fail pulse coincident with gclk_pf -> counted in the next record's fail_cnt, not the closing one.
REQ-033 rec_ready=0 for 6 windows with FIFO_DEPTH=4 -> 4 records are held, overflow=1, drop_cnt=2; the stored periods are 0..3 in order.
REQ-034 300 succ pulses in one window with CNT_WIDTH=8 -> succ_cnt=255, total_succ=300.
REQ-035 grst pulsed mid-window with 1 record queued -> the record is still delivered, the open window is discarded, and the period restarts at 0.
REQ-036 With SVA_COLLECT_SKIP_EMPTY_EN, 3 empty windows followed by 1 succ window -> a single record with period=3, succ_cnt=1.
